stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-channel to 1 stream multiplexer with a valid/ready handshake on every port.
//  Each cycle it selects one input channel, either from an explicit select input or by round-robin arbitration.
//  The selected word is captured in a single output register.
//  Used wherever several producers share one consumer link.
// PARAMETERS
//  N_CH    4                 number of input channels (2..16)
//  WIDTH   8                 data width per channel, in bits
//  SEL_W   $clog2(N_CH)      width of the select and channel-id fields (derived)
// PORTS
//  clk        in   1            single clock; all logic is rising-edge triggered
//  rst        in   1            reset: synchronous, active-high
//  mode       in   1            0 = manual select (uses sel), 1 = round-robin
//  sel        in   SEL_W        channel to forward in manual mode
//  in_data    in   N_CH*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N_CH         per-channel valid
//  in_ready   out  N_CH         per-channel ready (combinational)
//  out_data   out  WIDTH        registered output data
//  out_valid  out  1            registered output valid
//  out_ready  in   1            downstream ready
//  out_ch     out  SEL_W        source channel of the word in out_data
//  xfer_cnt   out  N_CH*16      per-channel accepted-word counters; present only with STREAM_MUX_CNT_EN
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_ch=0, rr_ptr=0, all xfer_cnt=0. All in_ready are 0 while rst=1.
//  - Slot free: load_en = ~out_valid | out_ready.
//  - Grant:
//    - At most one channel is granted per cycle.
//    - in_ready[i] = grant[i] & load_en.
//    - A transfer on channel i occurs when in_valid[i] & in_ready[i].
//  - Latency: one cycle. A word accepted at edge t appears on out_data at t+1 with out_valid=1.
//  - Output side:
//    - out_data and out_ch stay stable while out_valid & ~out_ready.
//    - Back-to-back throughput is 1 word/cycle while out_ready=1.
//    - If no input transfer occurs and out_ready=1, out_valid goes to 0 at the next edge.
//  - Manual mode (mode=0):
//    - grant[i] = (i==sel) & in_valid[i].
//    - sel >= N_CH grants nothing; no in_ready is asserted.
//  - Round-robin mode (mode=1):
//    - Search starts at rr_ptr and wraps modulo N_CH; the first channel found with in_valid is granted.
//    - After a transfer from channel k, rr_ptr <= (k+1) mod N_CH. The wrap from N_CH-1 goes to 0.
//    - rr_ptr is unchanged when no transfer occurs.
//  - Mode or sel changes:
//    - Take effect on the combinational grant in the same cycle.
//    - A word already held in the output register is never altered or dropped.
//  - rr_ptr is kept while in manual mode and is used again on return to round-robin.
//  - Simultaneous load and drain in one cycle (out_valid & out_ready & transfer): the new word replaces the old one. No bubble.
//  - Reset in mid-stream: the held output word is discarded, out_valid=0 on the following cycle, and rr_ptr returns to 0.
// CONFIGURATION
//  - STREAM_MUX_CNT_EN defined:
//    - xfer_cnt port is present.
//    - Counter i increments by 1 on each channel-i input transfer and saturates at 16'hFFFF.
//    - Cleared by rst.
//  - STREAM_MUX_CNT_EN undefined: the xfer_cnt port and its counters are absent. All other behaviour is identical.
// STRUCTURE
//  - Package stream_mux_pkg:
//    - MODE_SEL=1'b0, MODE_RR=1'b1.
//    - CNT_W=16, CNT_MAX=16'hFFFF.
//  - Sub-module rr_arbiter:
//    - Parameter N_CH.
//    - Inputs req[N_CH] and ptr[SEL_W]; outputs one-hot gnt[N_CH] and gnt_id[SEL_W].
//    - Purely combinational, implemented as a rotate, priority-encode, rotate-back.
//  - The top level holds the mode mux, the output register, rr_ptr and the optional counters.
// TESTING
//  1. Reset and manual mode:
//     - Stimulus: rst=1 for 2 cycles, then rst=0; mode=0, sel=2, all valid, ch2 data=8'hA5, out_ready=1.
//     - Response: out_valid=0 during reset. Next cycle out_data=A5, out_ch=2; only in_ready[2]=1.
//  2. Round-robin fairness:
//     - Stimulus: mode=1, all four channels valid continuously with data 8'h10..8'h13, out_ready=1.
//     - Response: out_ch sequence 0,1,2,3,0,1,... at one word per cycle.
//  3. Skip and wrap:
//     - Stimulus: mode=1, only ch1 and ch3 valid.
//     - Response: out_ch alternates 1,3,1,3. rr_ptr wraps 3 -> 0 and ch1 is still the next grant.
//  4. Backpressure:
//     - Stimulus: out_ready=0 for 5 cycles while ch0 valid with data 8'h3C.
//     - Response: one word captured; out_data=3C held stable; in_ready all 0 until out_ready=1.
//  5. Invalid select and reset mid-stream:
//     - Stimulus: mode=0, sel=3 with N_CH=3 -> no grant, out_valid stays 0. Then pulse rst while out_valid=1.
//     - Response: out_valid=0 on the cycle after rst.
//  6. Counters (STREAM_MUX_CNT_EN):
//     - Stimulus: 70000 transfers on ch0.
//     - Response: xfer_cnt[15:0] saturates at FFFF; other counters remain 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encodings and counter constants for stream_mux_rr
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: rotate, priority-encode, rotate back
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_id
);

    logic [2*N_CH-1:0] req_dbl;
    logic [2*N_CH-1:0] gnt_dbl;
    logic [N_CH-1:0]   rot_req;
    logic [N_CH-1:0]   rot_gnt;
    logic              found;

    always_comb begin
        req_dbl = {req, req} >> ptr;
        rot_req = req_dbl[N_CH-1:0];

        // Lowest set bit of the rotated vector is the first requester at or after ptr.
        rot_gnt = '0;
        found   = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            if (rot_req[j] && !found) begin
                rot_gnt[j] = 1'b1;
                found      = 1'b1;
            end
        end

        gnt_dbl = {rot_gnt, rot_gnt} << ptr;
        gnt     = gnt_dbl[2*N_CH-1:N_CH];

        gnt_id = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) gnt_id = SEL_W'(i);
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel to 1 stream mux, manual or round-robin select, registered output
// Optional per-channel transfer counters: STREAM_MUX_CNT_EN
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
`ifdef STREAM_MUX_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]   xfer_cnt
`endif
);

    logic [SEL_W-1:0] rr_ptr;
    logic [N_CH-1:0]  rr_gnt;
    logic [SEL_W-1:0] rr_gnt_id;
    logic [N_CH-1:0]  man_gnt;
    logic [N_CH-1:0]  grant;
    logic [N_CH-1:0]  xfer;
    logic             any_xfer;
    logic             load_en;
    logic [WIDTH-1:0] xfer_data;
    logic [SEL_W-1:0] xfer_id;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req    (in_valid),
        .ptr    (rr_ptr),
        .gnt    (rr_gnt),
        .gnt_id (rr_gnt_id)
    );

    always_comb begin
        load_en = ~out_valid | out_ready;

        // An out-of-range sel matches no index, so nothing is granted.
        man_gnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            man_gnt[i] = (int'(sel) == i) & in_valid[i];
        end

        grant    = (mode == MODE_SEL) ? man_gnt : rr_gnt;
        in_ready = rst ? '0 : (grant & {N_CH{load_en}});
        xfer     = in_valid & in_ready;
        any_xfer = |xfer;

        xfer_data = '0;
        xfer_id   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (xfer[i]) begin
                xfer_data = in_data[i*WIDTH +: WIDTH];
                xfer_id   = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load_en) begin
                out_valid <= any_xfer;
                if (any_xfer) begin
                    out_data <= xfer_data;
                    out_ch   <= xfer_id;
                end
            end
            // Pointer only advances on round-robin grants; manual traffic leaves it parked.
            if (any_xfer && mode == MODE_RR) begin
                rr_ptr <= (rr_gnt_id == SEL_W'(N_CH-1)) ? '0 : rr_gnt_id + 1'b1;
            end
        end
    end

`ifdef STREAM_MUX_CNT_EN
    logic [CNT_W-1:0] cnt [N_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (xfer[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        xfer_cnt = '0;
        for (int i = 0; i < N_CH; i++) xfer_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed self-checking bench for stream_mux_rr (4-channel and 3-channel instances)
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst, mode, out_ready, out_valid;
    logic [1:0]  sel, out_ch;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_data;

    logic        rst3, mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_ch3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;

`ifdef STREAM_MUX_CNT_EN
    logic [63:0] xfer_cnt;
    logic [47:0] xfer_cnt3;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch)
`ifdef STREAM_MUX_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_ch(out_ch3)
`ifdef STREAM_MUX_CNT_EN
        , .xfer_cnt(xfer_cnt3)
`endif
    );

    task automatic reset_main();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h03, 8'hA5, 8'h01, 8'h00};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b want 0", out_valid); miscompares++; end
            vectors++;
            if (in_ready !== 4'h0) begin $display("FAIL rst_in_ready: got %b want 0000", in_ready); miscompares++; end
        end
        vectors++;
        if (out_data !== 8'h00 || out_ch !== 2'd0) begin
            $display("FAIL rst_out_regs: got data %h ch %0d want 00 ch 0", out_data, out_ch); miscompares++;
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 4'b0100) begin $display("FAIL manual_in_ready: got %b want 0100", in_ready); miscompares++; end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            $display("FAIL manual_out: got v%b %h ch%0d want v1 a5 ch2", out_valid, out_data, out_ch); miscompares++;
        end
    endtask

    task automatic test_rr_fair();
        reset_main();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== 8'(8'h10 + k % 4)) begin
                $display("FAIL rr_fair[%0d]: got v%b ch%0d %h want v1 ch%0d %h",
                         k, out_valid, out_ch, out_data, k % 4, 8'h10 + k % 4);
                miscompares++;
            end
        end
    endtask

    task automatic test_skip_wrap();
        logic [1:0] exp_ch;
        reset_main();
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 6; k++) begin
            exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== {6'h04, exp_ch}) begin
                $display("FAIL skip_wrap[%0d]: got v%b ch%0d %h want v1 ch%0d %h",
                         k, out_valid, out_ch, out_data, exp_ch, {6'h04, exp_ch});
                miscompares++;
            end
        end
    endtask

    task automatic test_backpressure();
        reset_main();
        mode = 1'b1; in_valid = 4'b0001; out_ready = 1'b0;
        in_data = {8'h00, 8'h00, 8'h00, 8'h3C};
        #1;
        vectors++;
        if (in_ready !== 4'b0001) begin $display("FAIL bp_first_ready: got %b want 0001", in_ready); miscompares++; end
        @(negedge clk);
        in_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd0 || in_ready !== 4'h0) begin
                $display("FAIL bp_hold[%0d]: got v%b %h ch%0d rdy%b want v1 3c ch0 rdy0000",
                         c, out_valid, out_data, out_ch, in_ready);
                miscompares++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0001) begin $display("FAIL bp_release_ready: got %b want 0001", in_ready); miscompares++; end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            $display("FAIL bp_next_word: got v%b %h want v1 5a", out_valid, out_data); miscompares++;
        end
    endtask

    task automatic test_mode_switch();
        reset_main();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        @(negedge clk);
        @(negedge clk);
        mode = 1'b0; sel = 2'd0;
        @(negedge clk);
        vectors++;
        if (out_ch !== 2'd0 || out_data !== 8'h10) begin
            $display("FAIL switch_manual: got ch%0d %h want ch0 10", out_ch, out_data); miscompares++;
        end
        mode = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_ch !== 2'd2 || out_data !== 8'h12) begin
            $display("FAIL switch_rr_resume: got ch%0d %h want ch2 12", out_ch, out_data); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 4'h0) begin $display("FAIL mid_rst_ready: got %b want 0000", in_ready); miscompares++; end
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin $display("FAIL mid_rst_valid: got %b want 0", out_valid); miscompares++; end
        @(negedge clk);
        vectors++;
        if (out_ch !== 2'd0 || out_data !== 8'h10) begin
            $display("FAIL mid_rst_ptr: got ch%0d %h want ch0 10", out_ch, out_data); miscompares++;
        end
    endtask

    task automatic test_invalid_sel();
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {8'h22, 8'h77, 8'h00};
        @(negedge clk);
        rst3 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
                $display("FAIL bad_sel[%0d]: got rdy%b v%b want rdy000 v0", c, in_ready3, out_valid3); miscompares++;
            end
            @(negedge clk);
        end
        sel3 = 2'd1; out_ready3 = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid3 !== 1'b1 || out_data3 !== 8'h77 || out_ch3 !== 2'd1) begin
            $display("FAIL sel_recover: got v%b %h ch%0d want v1 77 ch1", out_valid3, out_data3, out_ch3); miscompares++;
        end
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        vectors++;
        if (out_valid3 !== 1'b0) begin $display("FAIL rst_mid_stream: got v%b want v0", out_valid3); miscompares++; end
    endtask

`ifdef STREAM_MUX_CNT_EN
    task automatic test_counters();
        reset_main();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        #1;
        vectors++;
        if (xfer_cnt !== 64'h0) begin $display("FAIL cnt_reset: got %h want 0", xfer_cnt); miscompares++; end
        for (int c = 0; c < 10; c++) @(negedge clk);
        vectors++;
        if (xfer_cnt[15:0] !== 16'd10) begin $display("FAIL cnt_ten: got %0d want 10", xfer_cnt[15:0]); miscompares++; end
        for (int c = 10; c < 70000; c++) @(negedge clk);
        vectors++;
        if (xfer_cnt !== 64'h0000_0000_0000_FFFF) begin
            $display("FAIL cnt_saturate: got %h want 000000000000ffff", xfer_cnt); miscompares++;
        end
    endtask
`endif

    initial begin
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1;
        test_reset();
        test_rr_fair();
        test_skip_wrap();
        test_backpressure();
        test_mode_switch();
        test_reset_mid();
        test_invalid_sel();
`ifdef STREAM_MUX_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
